// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, FIFO depth and bit-time default.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        WAITHI = 3'd4
    } rx_state_t;

    localparam int unsigned FIFO_DEPTH      = 4;
    localparam int unsigned CLK_PER_BIT_DEF = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive-byte storage: circular FIFO of Depth entries; Depth=1 acts as a single holding register.
module uart_rx_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wr_data,
    output logic [Width-1:0] rd_data,
    output logic             valid,
    output logic             full
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;
    logic [CntW-1:0]  count;
    logic             wr_en, rd_en;

    assign valid   = (count != '0);
    assign full    = (count == CntW'(Depth));
    assign rd_en   = pop & valid;
    // A simultaneous pop frees the slot, so a push into a full store is still accepted
    assign wr_en   = push & (~full | rd_en);
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, sticky error flags and byte storage.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register is used.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned ClkPerBit = CLK_PER_BIT_DEF,
    parameter int unsigned WordSize  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rx,
    input  logic                i_rd_n,
    output logic [WordSize-1:0] o_data,
    output logic                o_valid,
    output logic                o_frame_err,
    output logic                o_overrun
);

    localparam int unsigned CntW = $clog2(ClkPerBit);
    localparam int unsigned IdxW = (WordSize > 1) ? $clog2(WordSize) : 1;
    localparam logic [CntW-1:0] HalfLoad = CntW'(ClkPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(ClkPerBit - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(WordSize - 1);
`ifdef UART_RX_FIFO_EN
    localparam int unsigned StoreDepth = FIFO_DEPTH;
`else
    localparam int unsigned StoreDepth = 1;
`endif

    rx_state_t           state, state_nxt;
    logic [CntW-1:0]     cnt, cnt_nxt;
    logic [IdxW-1:0]     idx, idx_nxt;
    logic [WordSize-1:0] shreg, shreg_nxt;
    logic                sync1, rxs, rxs_q;
    logic                push, ferr_set, rd, full;

    // Synchroniser resets low so a line already low at reset release is not seen as a start edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b0;
            rxs   <= 1'b0;
            rxs_q <= 1'b0;
        end else begin
            sync1 <= i_rx;
            rxs   <= sync1;
            rxs_q <= rxs;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_q && !rxs) begin
                    state_nxt = START;
                    cnt_nxt   = HalfLoad;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        cnt_nxt   = FullLoad;
                        idx_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_nxt = {rxs, shreg[WordSize-1:1]};
                    cnt_nxt   = FullLoad;
                    if (idx == LastIdx) state_nxt = STOP;
                    else                idx_nxt   = idx + 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = WAITHI;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WAITHI: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd = ~i_rd_n & o_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (rd) begin
                o_frame_err <= 1'b0;
                o_overrun   <= 1'b0;
            end
            if (ferr_set)            o_frame_err <= 1'b1;
            if (push && full && !rd) o_overrun   <= 1'b1;
        end
    end

    uart_rx_fifo #(
        .Depth (StoreDepth),
        .Width (WordSize)
    ) u_store (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (push),
        .pop     (rd),
        .wr_data (shreg),
        .rd_data (o_data),
        .valid   (o_valid),
        .full    (full)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random frames against a queue-based model.
module tb_uart_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned WS  = 8;
`ifdef UART_RX_FIFO_EN
    localparam int unsigned DEPTH = 4;
`else
    localparam int unsigned DEPTH = 1;
`endif

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_rx    = 1'b1;
    logic       i_rd_n  = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_overrun;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic       m_ferr = 1'b0;
    logic       m_ovr  = 1'b0;

    uart_rx #(
        .ClkPerBit (CPB),
        .WordSize  (WS)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx        (i_rx),
        .i_rd_n      (i_rd_n),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_head();
        return (mq.size() != 0) ? mq[0] : 8'h00;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".valid"}, 32'(o_valid),     32'(mq.size() != 0));
        chk({tag, ".data"},  32'(o_data),      32'(m_head()));
        chk({tag, ".ferr"},  32'(o_frame_err), 32'(m_ferr));
        chk({tag, ".ovr"},   32'(o_overrun),   32'(m_ovr));
    endtask

    // Every task leaves time at 1 unit after a rising edge
    task automatic cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        i_rx = v;
        cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                              input bit lat_chk, input bit rd_at_push);
        drive_bit(1'b0);
        for (int k = 0; k < int'(WS); k++) drive_bit(b[k]);
        i_rx = stop_ok;
        for (int i = 0; i < int'(CPB); i++) begin
            @(posedge i_clk);
            #1;
            if (lat_chk && i == 5)  chk("lat.before", 32'(o_valid), 32'd0);
            if (lat_chk && i == 11) chk("lat.after",  32'(o_valid), 32'd1);
            if (rd_at_push && i == 9) begin
                i_rd_n = 1'b0;
                chk("rdpush.data", 32'(o_data), 32'(m_head()));
            end
            if (rd_at_push && i == 10) i_rd_n = 1'b1;
        end
        i_rx = 1'b1;
        if (rd_at_push && mq.size() != 0) begin
            void'(mq.pop_front());
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        if (stop_ok) begin
            if (mq.size() < int'(DEPTH)) mq.push_back(b);
            else                         m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        cycles(4);
    endtask

    task automatic do_read(input string tag);
        i_rd_n = 1'b0;
        chk({tag, ".rdata"}, 32'(o_data), 32'(m_head()));
        cycles(1);
        i_rd_n = 1'b1;
        if (mq.size() != 0) begin
            void'(mq.pop_front());
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        check_state(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        logic       rstop;

        // Reset state
        cycles(3);
        check_state("reset");
        i_rst_n = 1'b1;
        cycles(5);

        // Single frame, latency and read-back
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check_state("a5");
        do_read("a5rd");

        // Start-bit glitch then a good frame
        i_rx = 1'b0;
        cycles(4);
        i_rx = 1'b1;
        cycles(30);
        check_state("glitch");
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        check_state("3c");
        do_read("3crd");

        // Framing error, ignored read, recovery
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check_state("ferr");
        do_read("ferr_ign");
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        check_state("after_ferr");
        do_read("ferr_clr");

        // Overrun: one more frame than storage holds
        for (int i = 0; i <= int'(DEPTH); i++)
            send_frame((DEPTH == 1) ? 8'(8'h11 * (i + 1)) : 8'(i + 1), 1'b1, 1'b0, 1'b0);
        check_state("ovr");
        for (int i = 0; i < int'(DEPTH); i++) do_read("ovr_rd");

        // Read coinciding with push while full
        for (int i = 0; i < int'(DEPTH); i++) send_frame(8'(8'h66 + i), 1'b1, 1'b0, 1'b0);
        send_frame(8'h77, 1'b1, 1'b0, 1'b1);
        check_state("rdpush");
        for (int i = 0; i < int'(DEPTH); i++) do_read("rdpush_rd");

        // Random frames and reads
        for (int n = 0; n < 10; n++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            send_frame(rb, rstop, 1'b0, 1'b0);
            check_state("rnd");
            for (int r = int'($urandom_range(0, 2)); r > 0; r--) do_read("rnd_rd");
        end
        for (int i = 0; i <= int'(DEPTH); i++) do_read("drain");

        // Reset in the middle of a frame with data held and a flag set
        send_frame(8'h99, 1'b1, 1'b0, 1'b0);
        send_frame(8'h42, 1'b0, 1'b0, 1'b0);
        check_state("pre_rst");
        drive_bit(1'b0);
        for (int k = 0; k < 4; k++) drive_bit(1'b0);
        i_rx = 1'b0;
        cycles(8);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst.valid", 32'(o_valid),     32'd0);
        chk("rst.data",  32'(o_data),      32'd0);
        chk("rst.ferr",  32'(o_frame_err), 32'd0);
        chk("rst.ovr",   32'(o_overrun),   32'd0);
        mq.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        cycles(3);
        i_rx    = 1'b1;
        i_rst_n = 1'b1;
        cycles(20);
        check_state("post_rst");
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        check_state("c3");
        do_read("c3rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter ClkPerBit, default 16: i_clk cycles per serial bit, minimum 4.
REQ-002 SHALL have parameter WordSize, default 8: data bits per frame.
REQ-003 SHALL have port i_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_rx  input  1  serial line, idle high, asynchronous to i_clk.
REQ-006 SHALL have port i_rd_n  input  1  active-low read strobe; a low cycle consumes the held byte.
REQ-007 SHALL have port o_data  output  WordSize  oldest unread byte; all zeros when empty.
REQ-008 SHALL have port o_valid  output  1  high while at least one unread byte is held.
REQ-009 SHALL have port o_frame_err  output  1  sticky flag: stop bit sampled low.
REQ-010 SHALL have port o_overrun  output  1  sticky flag: byte received while storage was full.

Function
REQ-011 SHALL pass i_rx through a 2-flop synchroniser; all logic uses the synchronised value (rxs).
REQ-012 SHALL implement the states IDLE, START, DATA, STOP and WAITHI with a bit-time counter of width clog2(ClkPerBit) and a bit index of width clog2(WordSize).
REQ-013 IDLE: a rxs high-to-low transition SHALL enter START and load the counter for ClkPerBit/2 cycles.
REQ-014 START: at counter expiry, SHALL re-sample rxs; high means a glitch and returns to IDLE; low enters DATA.
REQ-015 DATA: SHALL sample rxs every ClkPerBit cycles at mid-bit and shift it in LSB first; after WordSize samples, SHALL enter STOP.
REQ-016 STOP: after ClkPerBit cycles, SHALL sample rxs; high pushes the byte to storage and returns to IDLE.
REQ-017 STOP: a low sample SHALL discard the byte, set o_frame_err and enter WAITHI; WAITHI returns to IDLE when rxs is high.
REQ-018 o_valid and o_data SHALL update on the cycle after the stop-sample cycle.
REQ-019 A read SHALL be i_rd_n low while o_valid is high; it pops one byte and clears o_frame_err and o_overrun.
REQ-020 i_rd_n low while o_valid is low SHALL be ignored and SHALL leave flags unchanged.
REQ-021 A push while storage is full SHALL drop the new byte, keep the stored bytes and set o_overrun.
REQ-022 A push and a read in the same cycle while full SHALL pop the old byte, store the new one and leave o_overrun clear.
REQ-023 o_data SHALL be combinational from the storage head so the data-bus multiplexer sees it in the read cycle.

Reset
REQ-024 Asserting i_rst_n low at any time SHALL immediately force IDLE, empty storage and all-zero outputs, including during a frame.
REQ-025 After deassertion, reception SHALL begin only at the next falling edge of rxs; a partial frame in progress is not recovered.

Configuration
REQ-026 With UART_RX_FIFO_EN defined, storage SHALL be a 4-entry FIFO (first in, first out, wrap-around pointers).
REQ-027 Without UART_RX_FIFO_EN, storage SHALL be a single holding register with full equal to o_valid.

Structure
REQ-028 The shared package SHALL hold the state encoding, the FIFO depth constant (4) and the ClkPerBit default.
REQ-029 Storage SHALL be the sub-module uart_rx_fifo, with depth 1 when UART_RX_FIFO_EN is absent.

Verification
All scenarios use ClkPerBit=16 and WordSize=8.
REQ-030 Frame 0xA5 sent -> o_valid rises 1 cycle after the stop sample (about 152 cycles after the start edge), o_data=0xA5; one i_rd_n pulse -> o_valid=0, o_data=0x00.
REQ-031 i_rx low for 4 cycles, then high -> no o_valid, FSM returns to IDLE; a following frame 0x3C is received correctly.
REQ-032 Frame 0x5A with stop bit low -> o_frame_err=1, o_valid=0; a read strobe is ignored; the next good frame 0x01 gives o_valid=1, and reading it clears o_frame_err.
REQ-033 No FIFO, frames 0x11 then 0x22 with no read -> o_data=0x11, o_overrun=1; FIFO, frames 0x01 to 0x05 -> 4 bytes read back as 0x01 to 0x04, o_overrun=1.
REQ-034 Read asserted in the same cycle as the push of 0x77 while full holding 0x66 -> read returns 0x66, then o_data=0x77, o_overrun=0.
REQ-035 i_rst_n pulsed low during bit 4 of a frame -> all outputs 0 at once; the next complete frame 0xC3 is received correctly.
